uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the FIFO entry count; it must be a power of two between 4 and 64.
REQ-002 SHALL have parameter BASE_ADDR, default 16'hF000, giving the I/O address of the data port; the status port is BASE_ADDR+1.
REQ-003 SHALL have port sys_clk_i, input, width 1: the single clock (vga_clk domain).
REQ-004 SHALL have port sys_rst_i, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_dat_i, input, width 8: received byte from the UART.
REQ-006 SHALL have port rx_valid_i, input, width 1: UART holds a byte; stays high until acknowledged.
REQ-007 SHALL have port rx_ack_o, output, width 1: one-cycle read strobe to the UART that releases the held byte.
REQ-008 SHALL have port io_rd_i, input, width 1: J1 I/O read strobe.
REQ-009 SHALL have port io_wr_i, input, width 1: J1 I/O write strobe.
REQ-010 SHALL have port io_addr_i, input, width 16: J1 I/O address.
REQ-011 SHALL have port io_din_i, input, width 16: J1 write data.
REQ-012 SHALL have port io_dout_o, output, width 16: read data, combinational from io_addr_i and state.
REQ-013 SHALL have port hit_o, output, width 1: high when io_addr_i equals BASE_ADDR or BASE_ADDR+1; the top-level read mux uses it.

Function
REQ-014 SHALL implement a capture FSM with three states:
- IDLE: if rx_valid_i, go to ACK.
- ACK: assert rx_ack_o for exactly one cycle, push rx_dat_i, go to WAIT.
- WAIT: go to IDLE once rx_valid_i is low.
REQ-015 SHALL push on ACK only when the FIFO is not full or a pop occurs in the same cycle; otherwise it SHALL drop the byte, still ack, and set sticky ovf.
REQ-016 SHALL make io_dout_o at BASE_ADDR equal to {8'h00, head byte} when the FIFO is non-empty, and 16'h0000 when empty.
REQ-017 SHALL pop at the clock edge ending a cycle with io_rd_i=1 and io_addr_i=BASE_ADDR and the FIFO non-empty; a read while empty SHALL leave all state unchanged.
REQ-018 SHALL encode the status word at BASE_ADDR+1 as: bit0 not_empty, bit1 full, bit2 ovf, bits[8:3] count (zero-extended), all other bits 0.
REQ-019 SHALL decode a write to BASE_ADDR+1 as follows:
- io_din_i[2]=1 clears ovf.
- io_din_i[7]=1 flushes the FIFO (pointers and count to 0).
- Both bits act in the same cycle.
- A flush SHALL override a simultaneous push or pop.
REQ-020 SHALL, on a simultaneous push and pop, advance both pointers and leave count unchanged, including at full and at DEPTH-1.
REQ-021 SHALL wrap pointers modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide and SHALL never exceed DEPTH.
REQ-022 SHALL ignore writes to BASE_ADDR; the UART transmit path is outside this block.
REQ-023 SHALL make hit_o and io_dout_o combinational with zero latency; all state changes SHALL occur on the rising edge of sys_clk_i.

Reset
REQ-024 SHALL, while sys_rst_i is high at a clock edge, set: FSM to IDLE, rx_ack_o=0, pointers=0, count=0, ovf=0, and the overflow counter (if present) to 0. FIFO storage SHALL NOT be cleared.
REQ-025 SHALL, when reset is asserted mid-ACK or mid-WAIT, abandon the transfer; after reset, a still-high rx_valid_i SHALL be captured as a fresh byte.

Configuration
REQ-026 SHALL, when UART_RX_FIFO_OVFCNT_EN is defined, add a 16-bit saturating dropped-byte counter readable at BASE_ADDR+2 and cleared by any write there; hit_o SHALL then also cover BASE_ADDR+2.
REQ-027 SHALL, without UART_RX_FIFO_OVFCNT_EN, have no counter, and BASE_ADDR+2 SHALL NOT assert hit_o.

Structure
REQ-028 SHALL place in shared package zx_io_pkg:
- the I/O port address constants (F000 data, F001 status, F002 border, F003/F004 timer, F005 line);
- the status-bit index constants;
- the capture-FSM state enum.
REQ-029 SHALL instantiate one sub-module, fifo_sync: a DEPTH x 8 synchronous FIFO with push/pop/flush and count, reusable for a future TX buffer.

Verification
REQ-030 SHALL verify single byte: 8'h41 with rx_valid_i held 3 cycles -> exactly one rx_ack_o pulse; status reads 16'h0009; data read returns 16'h0041; status then reads 16'h0000.
REQ-031 SHALL verify fill with default DEPTH: 16 bytes 0x00..0x0F -> status 16'h0083; a 17th byte 0xAA is acked and dropped; status 16'h0087; reads return 0x00..0x0F in order.
REQ-032 SHALL verify simultaneous events: at count=16, push 0x55 in the same cycle as a data read -> read returns the oldest byte; count stays 16; 0x55 is the last byte out; ovf stays 0.
REQ-033 SHALL verify empty read and flush: data read when empty -> 16'h0000 with count 0; write 16'h0084 with 5 entries and ovf set -> status 16'h0000.
REQ-034 SHALL verify reset mid-ACK: assert sys_rst_i in the ACK cycle -> count 0, rx_ack_o low; with rx_valid_i still high after release, the byte is captured once.
REQ-035 SHALL verify, with UART_RX_FIFO_OVFCNT_EN defined: 3 dropped bytes -> BASE_ADDR+2 reads 16'h0003; a write there reads back 16'h0000.

Source files
------------

// File: rtl/zx_io_pkg.sv
// Shared J1 I/O map for the ZX platform: port addresses, UART status bit
// positions, control bits and the UART capture-FSM state type.
package zx_io_pkg;

    localparam logic [15:0] IO_UART_DATA = 16'hF000;
    localparam logic [15:0] IO_UART_STAT = 16'hF001;
    localparam logic [15:0] IO_BORDER    = 16'hF002;
    localparam logic [15:0] IO_TIMER_LO  = 16'hF003;
    localparam logic [15:0] IO_TIMER_HI  = 16'hF004;
    localparam logic [15:0] IO_LINE      = 16'hF005;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 3;

    localparam int CTL_CLR_OVF  = 2;
    localparam int CTL_FLUSH    = 7;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_ACK  = 2'd1,
        CAP_WAIT = 2'd2
    } cap_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock DEPTH x WIDTH FIFO with push/pop/flush and occupancy count.
// Storage is never reset; only pointers and count are.
module fifo_sync #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive capture into a FIFO, exposed on the J1 I/O bus (data + status).
// Define UART_RX_FIFO_OVFCNT_EN to add a saturating dropped-byte counter at BASE_ADDR+2.
module uart_rx_fifo
    import zx_io_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] BASE_ADDR = IO_UART_DATA
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_valid_i,
    output logic        rx_ack_o,
    input  logic        io_rd_i,
    input  logic        io_wr_i,
    input  logic [15:0] io_addr_i,
    input  logic [15:0] io_din_i,
    output logic [15:0] io_dout_o,
    output logic        hit_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;

    cap_state_e    r_state;
    cap_state_e    w_state_nxt;
    logic          w_ack_st;
    logic          w_sel_data;
    logic          w_sel_stat;
    logic          w_pop;
    logic          w_drop;
    logic          w_clr_ovf;
    logic          w_flush;
    logic          w_full;
    logic          w_empty;
    logic          r_ovf;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic [15:0]   w_status;
    logic          w_unused_din;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) r_state <= CAP_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack_st    = 1'b0;
        case (r_state)
            CAP_IDLE: if (rx_valid_i) w_state_nxt = CAP_ACK;
            CAP_ACK: begin
                w_ack_st    = 1'b1;
                w_state_nxt = CAP_WAIT;
            end
            CAP_WAIT: if (!rx_valid_i) w_state_nxt = CAP_IDLE;
            default:  w_state_nxt = CAP_IDLE;
        endcase
    end

    // Masked by reset so an abandoned ACK never releases the UART's byte.
    assign rx_ack_o = w_ack_st & ~sys_rst_i;

    assign w_sel_data = (io_addr_i == BASE_ADDR);
    assign w_sel_stat = (io_addr_i == STAT_ADDR);
    assign w_pop      = io_rd_i & w_sel_data & ~w_empty;
    assign w_drop     = rx_ack_o & w_full & ~w_pop;
    assign w_clr_ovf  = io_wr_i & w_sel_stat & io_din_i[CTL_CLR_OVF];
    assign w_flush    = io_wr_i & w_sel_stat & io_din_i[CTL_FLUSH];
    assign w_unused_din = &{1'b0, io_din_i[15:8], io_din_i[6:3], io_din_i[1:0]};

    fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (sys_clk_i),
        .i_rst   (sys_rst_i),
        .i_push  (rx_ack_o),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (rx_dat_i),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A drop in the same cycle as a clear leaves ovf set so the event is not lost.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) r_ovf <= 1'b0;
        else           r_ovf <= (r_ovf & ~w_clr_ovf) | w_drop;
    end

    always_comb begin
        w_status = '0;
        w_status[ST_NOT_EMPTY]           = ~w_empty;
        w_status[ST_FULL]                = w_full;
        w_status[ST_OVF]                 = r_ovf;
        w_status[ST_COUNT_LSB +: CW]     = w_count;
    end

`ifdef UART_RX_FIFO_OVFCNT_EN
    localparam logic [15:0] OCNT_ADDR = BASE_ADDR + 16'd2;

    logic        w_sel_ocnt;
    logic [15:0] r_ocnt;

    assign w_sel_ocnt = (io_addr_i == OCNT_ADDR);
    assign hit_o      = w_sel_data | w_sel_stat | w_sel_ocnt;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || (io_wr_i && w_sel_ocnt)) r_ocnt <= '0;
        else if (w_drop && (r_ocnt != 16'hFFFF))  r_ocnt <= r_ocnt + 16'd1;
    end
`else
    assign hit_o = w_sel_data | w_sel_stat;
`endif

    always_comb begin
        io_dout_o = '0;
        if (w_sel_data)      io_dout_o = w_empty ? 16'h0000 : {8'h00, w_head};
        else if (w_sel_stat) io_dout_o = w_status;
`ifdef UART_RX_FIFO_OVFCNT_EN
        else if (w_sel_ocnt) io_dout_o = r_ocnt;
`endif
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios then random traffic,
// all expectations from a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
    import zx_io_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'hF000;

    logic        sys_clk_i  = 1'b0;
    logic        sys_rst_i  = 1'b1;
    logic [7:0]  rx_dat_i   = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ack_o;
    logic        io_rd_i    = 1'b0;
    logic        io_wr_i    = 1'b0;
    logic [15:0] io_addr_i  = 16'h0000;
    logic [15:0] io_din_i   = 16'h0000;
    logic [15:0] io_dout_o;
    logic        hit_o;

    uart_rx_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .sys_clk_i  (sys_clk_i),
        .sys_rst_i  (sys_rst_i),
        .rx_dat_i   (rx_dat_i),
        .rx_valid_i (rx_valid_i),
        .rx_ack_o   (rx_ack_o),
        .io_rd_i    (io_rd_i),
        .io_wr_i    (io_wr_i),
        .io_addr_i  (io_addr_i),
        .io_din_i   (io_din_i),
        .io_dout_o  (io_dout_o),
        .hit_o      (hit_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int n_checks  = 0;
    int n_errors  = 0;
    int acks_seen = 0;
    int exp_acks  = 0;

    logic [7:0]  mq[$];
    bit          m_ovf  = 1'b0;
    logic [15:0] m_ocnt = 16'h0000;

    logic [16:0] exp_q[$];
    string       name_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_status();
        int c;
        logic [15:0] s;
        c = mq.size();
        s = 16'h0000;
        s[0]   = (c != 0);
        s[1]   = (c == DEPTH);
        s[2]   = m_ovf;
        s[8:3] = c[5:0];
        return s;
    endfunction

    function automatic logic [16:0] model_read(input logic [15:0] a);
        if (a == BASE) return {1'b1, (mq.size() != 0) ? {8'h00, mq[0]} : 16'h0000};
        if (a == BASE + 16'd1) return {1'b1, model_status()};
`ifdef UART_RX_FIFO_OVFCNT_EN
        if (a == BASE + 16'd2) return {1'b1, m_ocnt};
`endif
        return 17'h0;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else begin
            m_ovf = 1'b1;
            if (m_ocnt != 16'hFFFF) m_ocnt = m_ocnt + 16'd1;
        end
    endfunction

    // Monitor: counts ack pulses and checks every bus read against the scoreboard.
    always @(negedge sys_clk_i) begin
        string nm;
        if (!sys_rst_i && rx_ack_o) acks_seen++;
        if (io_rd_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL monitor: read with no expectation, got %0h", io_dout_o);
            end else begin
                nm = name_q.pop_front();
                chk(nm, 32'({hit_o, io_dout_o}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic bus_read(input logic [15:0] a, input string nm,
                            input bit use_c = 1'b0, input logic [16:0] c = 17'h0);
        @(posedge sys_clk_i); #1;
        io_addr_i = a;
        io_rd_i   = 1'b1;
        exp_q.push_back(use_c ? c : model_read(a));
        name_q.push_back(nm);
        @(posedge sys_clk_i);
        if (a == BASE && mq.size() != 0) void'(mq.pop_front());
        #1 io_rd_i = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(posedge sys_clk_i); #1;
        io_addr_i = a;
        io_din_i  = d;
        io_wr_i   = 1'b1;
        @(posedge sys_clk_i);
        if (a == BASE + 16'd1) begin
            if (d[2]) m_ovf = 1'b0;
            if (d[7]) mq.delete();
        end
`ifdef UART_RX_FIFO_OVFCNT_EN
        if (a == BASE + 16'd2) m_ocnt = 16'h0000;
`endif
        #1 io_wr_i = 1'b0;
    endtask

    task automatic wait_ack(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk_i);
            if (rx_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no rx_ack_o within 20 cycles", nm);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int extra);
        @(posedge sys_clk_i); #1;
        rx_dat_i   = b;
        rx_valid_i = 1'b1;
        wait_ack("send_ack");
        @(posedge sys_clk_i);
        model_push(b);
        exp_acks++;
        repeat (extra) @(posedge sys_clk_i);
        #1 rx_valid_i = 1'b0;
    endtask

    // UART byte arrives in the same cycle as a data-port read.
    task automatic sim_push_pop(input logic [7:0] b);
        @(posedge sys_clk_i); #1;
        rx_dat_i   = b;
        rx_valid_i = 1'b1;
        @(posedge sys_clk_i); #1;
        io_addr_i = BASE;
        io_rd_i   = 1'b1;
        exp_q.push_back(model_read(BASE));
        name_q.push_back("simul_read");
        @(negedge sys_clk_i);
        chk("simul_ack", 32'(rx_ack_o), 32'd1);
        @(posedge sys_clk_i);
        if (mq.size() != 0) void'(mq.pop_front());
        model_push(b);
        exp_acks++;
        #1;
        io_rd_i    = 1'b0;
        rx_valid_i = 1'b0;
    endtask

    task automatic reset_mid_ack(input logic [7:0] b);
        @(posedge sys_clk_i); #1;
        rx_dat_i   = b;
        rx_valid_i = 1'b1;
        @(posedge sys_clk_i); #1;
        sys_rst_i = 1'b1;
        @(posedge sys_clk_i);
        mq.delete();
        m_ovf  = 1'b0;
        m_ocnt = 16'h0000;
        #1;
        sys_rst_i = 1'b0;
        io_addr_i = BASE + 16'd1;
        io_rd_i   = 1'b1;
        exp_q.push_back({1'b1, 16'h0000});
        name_q.push_back("rstack_status");
        @(negedge sys_clk_i);
        chk("rstack_ack_low", 32'(rx_ack_o), 32'd0);
        @(posedge sys_clk_i); #1;
        io_rd_i = 1'b0;
        wait_ack("rstack_recapture");
        @(posedge sys_clk_i);
        model_push(b);
        exp_acks++;
        #1 rx_valid_i = 1'b0;
    endtask

    initial begin
        int          op;
        logic [15:0] d;
        logic [15:0] a;

        repeat (3) @(posedge sys_clk_i);
        #1 sys_rst_i = 1'b0;

        // Reset state
        chk("rst_ack", 32'(rx_ack_o), 32'd0);
        bus_read(BASE + 16'd1, "rst_status", 1'b1, {1'b1, 16'h0000});
        bus_read(BASE, "rst_data", 1'b1, {1'b1, 16'h0000});

        // Single byte, valid held 3 cycles
        send_byte(8'h41, 1);
        @(posedge sys_clk_i);
        chk("single_ack_count", 32'(acks_seen), 32'd1);
        bus_read(BASE + 16'd1, "single_status", 1'b1, {1'b1, 16'h0009});
        bus_read(BASE, "single_data", 1'b1, {1'b1, 16'h0041});
        bus_read(BASE + 16'd1, "single_status_after", 1'b1, {1'b1, 16'h0000});

        // Fill and overflow
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        bus_read(BASE + 16'd1, "fill_status", 1'b1, {1'b1, 16'h0083});
        send_byte(8'hAA, 0);
        bus_read(BASE + 16'd1, "ovf_status", 1'b1, {1'b1, 16'h0087});
        for (int i = 0; i < 16; i++) bus_read(BASE, "fill_drain", 1'b1, {1'b1, 8'h00, 8'(i)});

        // Empty read and flush with ovf clear
        bus_read(BASE, "empty_data", 1'b1, {1'b1, 16'h0000});
        bus_read(BASE + 16'd1, "empty_status", 1'b1, {1'b1, 16'h0004});
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 0);
        bus_read(BASE + 16'd1, "preflush_status", 1'b1, {1'b1, 16'h002D});
        bus_write(BASE + 16'd1, 16'h0084);
        bus_read(BASE + 16'd1, "flush_status", 1'b1, {1'b1, 16'h0000});
        bus_write(BASE, 16'h00FF);
        bus_read(BASE + 16'd1, "data_write_ignored", 1'b1, {1'b1, 16'h0000});

        // Simultaneous push and pop at full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 0);
        bus_read(BASE + 16'd1, "simul_pre_status", 1'b1, {1'b1, 16'h0083});
        sim_push_pop(8'h55);
        bus_read(BASE + 16'd1, "simul_post_status", 1'b1, {1'b1, 16'h0083});
        for (int i = 0; i < 15; i++) bus_read(BASE, "simul_drain", 1'b1, {1'b1, 8'h00, 8'(8'h11 + i)});
        bus_read(BASE, "simul_last", 1'b1, {1'b1, 16'h0055});
        bus_read(BASE + 16'd1, "simul_end_status", 1'b1, {1'b1, 16'h0000});

`ifdef UART_RX_FIFO_OVFCNT_EN
        bus_write(BASE + 16'd2, 16'h0000);
        for (int i = 0; i < 19; i++) send_byte(8'(i), 0);
        bus_read(BASE + 16'd2, "ocnt_three", 1'b1, {1'b1, 16'h0003});
        bus_write(BASE + 16'd2, 16'h1234);
        bus_read(BASE + 16'd2, "ocnt_cleared", 1'b1, {1'b1, 16'h0000});
`else
        bus_read(BASE + 16'd2, "no_ocnt_hit", 1'b1, {1'b0, 16'h0000});
`endif

        // Reset in the ACK cycle
        for (int i = 0; i < 3; i++) send_byte(8'(8'hE0 + i), 0);
        reset_mid_ack(8'h5A);
        bus_read(BASE + 16'd1, "rstack_after_status", 1'b1, {1'b1, 16'h0009});
        bus_read(BASE, "rstack_data", 1'b1, {1'b1, 16'h005A});
        bus_read(BASE + 16'd1, "rstack_empty_status", 1'b1, {1'b1, 16'h0000});

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 10));
            case (op)
                0, 1, 2, 3: send_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
                4, 5: bus_read(BASE, "rnd_data");
                6: bus_read(BASE + 16'd1, "rnd_status");
                7: begin
                    d = 16'($urandom);
                    if ($urandom_range(0, 3) != 0) d[7] = 1'b0;
                    a = BASE + 16'($urandom_range(0, 2));
                    bus_write(a, d);
                end
                8: bus_read(BASE - 16'd2 + 16'($urandom_range(0, 5)), "rnd_addr");
                9: bus_read(16'($urandom), "rnd_far_addr");
                default: sim_push_pop(8'($urandom_range(0, 255)));
            endcase
        end

        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        chk("total_acks", 32'(acks_seen), 32'(exp_acks));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
